// File: rtl/addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor.
//   OP_ADD / OP_SUB : encoding of the sub input
//   FL_*            : bit positions inside the 6-bit flag bundle
//                     {cf, of, zf, pf, slt, sltu}
//   DEF_WIDTH/CHUNK : default operand width and bits per pipeline stage
package addsub_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   localparam int FL_CF   = 5;
   localparam int FL_OF   = 4;
   localparam int FL_ZF   = 3;
   localparam int FL_PF   = 2;
   localparam int FL_SLT  = 1;
   localparam int FL_SLTU = 0;

   typedef logic [5:0] flags_t;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CHUNK = 8;

endpackage

// File: rtl/addsub_chunk.sv
// Combinational CHUNK-bit adder slice.
//   x, y  : slice operands (y already inverted for subtraction)
//   ci    : carry into the slice
//   sum   : slice sum
//   co    : carry out of the slice
//   c_msb : carry into the slice MSB (used for signed overflow)
module addsub_chunk #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] x,
   input  logic [CHUNK-1:0] y,
   input  logic             ci,
   output logic [CHUNK-1:0] sum,
   output logic             co,
   output logic             c_msb
);

   logic [CHUNK:0] full;

   assign full  = {1'b0, x} + {1'b0, y} + (CHUNK + 1)'(ci);
   assign sum   = full[CHUNK-1:0];
   assign co    = full[CHUNK];
   // sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out directly
   assign c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ sum[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK-bit slice per stage,
// with valid/ready handshake and the full ALU flag set.
// Latency STAGES = WIDTH/CHUNK cycles, throughput one result per cycle.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, sub)
//   out_valid/out_ready : result handshake (s and flags)
//   cf, of, zf, pf      : carry/borrow, signed overflow, zero, odd parity
//   slt, sltu           : signed / unsigned less-than (A - B)
// Optional feature macro ADDSUB_SAT_EN adds input sat (signed saturation on
// overflow, travels with its operation) and output sat_hit.
module pipelined_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CHUNK = DEF_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cf,
   output logic             of,
   output logic             zf,
   output logic             pf,
   output logic             slt,
   output logic             sltu
`ifdef ADDSUB_SAT_EN
   ,
   input  logic             sat,
   output logic             sat_hit
`endif
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int L      = STAGES - 1;

   logic             adv;
   logic [WIDTH-1:0] bx;

   // Per-stage view: *_in feeds slice k, *_q is the register after slice k.
   // ax holds finished result chunks below slice k and raw A chunks above.
   logic [WIDTH-1:0] ax_in  [STAGES];
   logic [WIDTH-1:0] bx_in  [STAGES];
   logic [WIDTH-1:0] ax_nxt [STAGES];
   logic             ci     [STAGES];
   logic             v_in   [STAGES];
   logic             sb_in  [STAGES];
   logic [CHUNK-1:0] sum    [STAGES];
   logic             co     [STAGES];
   logic             c_msb  [STAGES];

   logic [WIDTH-1:0] ax_q   [STAGES];
   logic [WIDTH-1:0] bx_q   [STAGES];
   logic             c_q    [STAGES];
   logic             v_q    [STAGES];
   logic             sb_q   [STAGES];

   logic [WIDTH-1:0] s_d, s_q, raw;
   flags_t           fl_d, fl_q;
   logic             cf_d, of_d;

`ifdef ADDSUB_SAT_EN
   logic             st_in  [STAGES];
   logic             st_q   [STAGES];
   logic             hit_d, hit_q;
`endif

   assign adv      = ~v_q[L] | out_ready;
   assign in_ready = adv;
   assign bx       = b ^ {WIDTH{sub == OP_SUB}};

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);

      if (k == 0) begin : g_src
         assign ax_in[k] = a;
         assign bx_in[k] = bx;
         assign ci[k]    = sub;
         assign v_in[k]  = in_valid;
         assign sb_in[k] = sub;
`ifdef ADDSUB_SAT_EN
         assign st_in[k] = sat;
`endif
      end else begin : g_src
         assign ax_in[k] = ax_q[k-1];
         assign bx_in[k] = bx_q[k-1];
         assign ci[k]    = c_q[k-1];
         assign v_in[k]  = v_q[k-1];
         assign sb_in[k] = sb_q[k-1];
`ifdef ADDSUB_SAT_EN
         assign st_in[k] = st_q[k-1];
`endif
      end

      addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
         .x     (ax_in[k][k*CHUNK +: CHUNK]),
         .y     (bx_in[k][k*CHUNK +: CHUNK]),
         .ci    (ci[k]),
         .sum   (sum[k]),
         .co    (co[k]),
         .c_msb (c_msb[k])
      );

      // Replace A's chunk k with the freshly computed result chunk
      assign ax_nxt[k] = (ax_in[k] & ~MASK) | (WIDTH'(sum[k]) << (k * CHUNK));
   end

   // Final stage: full result is aligned in ax_nxt[L]; the top chunk of
   // ax_in[L] is still operand A, so its MSB gives A's sign for clamping.
   always_comb begin
      raw  = ax_nxt[L];
      cf_d = sb_in[L] ^ co[L];
      of_d = co[L] ^ c_msb[L];
      s_d  = raw;
`ifdef ADDSUB_SAT_EN
      hit_d = st_in[L] & of_d;
      if (hit_d) begin
         s_d = ax_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
      fl_d          = '0;
      fl_d[FL_CF]   = cf_d;
      fl_d[FL_OF]   = of_d;
      fl_d[FL_ZF]   = ~|s_d;
      fl_d[FL_PF]   = ^s_d;
      fl_d[FL_SLT]  = of_d ^ raw[WIDTH-1];
      fl_d[FL_SLTU] = cf_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            ax_q[k] <= '0;
            bx_q[k] <= '0;
            c_q[k]  <= 1'b0;
            v_q[k]  <= 1'b0;
            sb_q[k] <= OP_ADD;
`ifdef ADDSUB_SAT_EN
            st_q[k] <= 1'b0;
`endif
         end
         s_q  <= '0;
         fl_q <= '0;
`ifdef ADDSUB_SAT_EN
         hit_q <= 1'b0;
`endif
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            ax_q[k] <= ax_nxt[k];
            bx_q[k] <= bx_in[k];
            c_q[k]  <= co[k];
            v_q[k]  <= v_in[k];
            sb_q[k] <= sb_in[k];
`ifdef ADDSUB_SAT_EN
            st_q[k] <= st_in[k];
`endif
         end
         s_q  <= s_d;
         fl_q <= fl_d;
`ifdef ADDSUB_SAT_EN
         hit_q <= hit_d;
`endif
      end
   end

   assign out_valid = v_q[L];
   assign s         = s_q;
   assign cf        = fl_q[FL_CF];
   assign of        = fl_q[FL_OF];
   assign zf        = fl_q[FL_ZF];
   assign pf        = fl_q[FL_PF];
   assign slt       = fl_q[FL_SLT];
   assign sltu      = fl_q[FL_SLTU];
`ifdef ADDSUB_SAT_EN
   assign sat_hit   = hit_q;
`endif

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: a 32/8 instance (latency 4) and a
// 16/16 instance (latency 1). Stimulus pushes expected results into queues,
// monitors pop and compare on each output handshake.
module tb_pipelined_addsub;

   localparam int ST0 = 4;

   logic clk;
   logic rst;
   int   cyc = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // 32-bit / 8-bit instance
   logic        in_valid, in_ready, sub, out_valid, out_ready;
   logic [31:0] a, b, s;
   logic        cf, of, zf, pf, slt, sltu;
   logic        sat_drv, sat_hit;
   logic [5:0]  fl0;
   assign fl0 = {cf, of, zf, pf, slt, sltu};

   // 16-bit / 16-bit instance
   logic        in_valid1, in_ready1, sub1, out_valid1;
   logic [15:0] a1, b1, s1;
   logic        cf1, of1, zf1, pf1, slt1, sltu1;
   logic [5:0]  fl1;
   assign fl1 = {cf1, of1, zf1, pf1, slt1, sltu1};

   pipelined_addsub #(.WIDTH(32), .CHUNK(8)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .cf(cf), .of(of), .zf(zf), .pf(pf), .slt(slt), .sltu(sltu)
`ifdef ADDSUB_SAT_EN
      , .sat(sat_drv), .sat_hit(sat_hit)
`endif
   );

   pipelined_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .sub(sub1), .out_valid(out_valid1), .out_ready(1'b1),
      .s(s1), .cf(cf1), .of(of1), .zf(zf1), .pf(pf1), .slt(slt1), .sltu(sltu1)
`ifdef ADDSUB_SAT_EN
      , .sat(1'b0), .sat_hit()
`endif
   );

   typedef struct {
      logic [31:0] s;
      logic [5:0]  fl;
      logic        hit;
      bit          lat;
      int          due;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor for the 32-bit instance, including hold-under-backpressure check
   logic        hold_pend = 1'b0;
   logic [31:0] hold_s;
   logic [5:0]  hold_fl;

   always @(negedge clk) begin
      #2;
      if (rst) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_s", s, hold_s);
            chk("hold_flags", 32'(fl0), 32'(hold_fl));
         end
         hold_pend = out_valid && !out_ready;
         hold_s    = s;
         hold_fl   = fl0;
         if (out_valid && out_ready) begin
            if (q0.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_out0: got s=%h with no pending op (cycle %0d)", s, cyc);
            end else begin
               e0 = q0.pop_front();
               chk("s0", s, e0.s);
               chk("flags0", 32'(fl0), 32'(e0.fl));
`ifdef ADDSUB_SAT_EN
               chk("sat_hit0", 32'(sat_hit), 32'(e0.hit));
`endif
               if (e0.lat) chk("latency0", 32'(cyc), 32'(e0.due));
            end
         end
      end
   end

   always @(negedge clk) begin
      #2;
      if (!rst && out_valid1) begin
         if (q1.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_out1: got s=%h with no pending op (cycle %0d)", s1, cyc);
         end else begin
            e1 = q1.pop_front();
            chk("s1", 32'(s1), e1.s);
            chk("flags1", 32'(fl1), 32'(e1.fl));
            chk("latency1", 32'(cyc), 32'(e1.due));
         end
      end
   end

   task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        input logic isat, input logic [31:0] es, input logic [5:0] efl,
                        input logic ehit, input bit lat);
      exp_t e;
      bit   done;
      done = 1'b0;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         a = ia; b = ib; sub = isub; sat_drv = isat;
         in_valid = 1'b1; out_ready = 1'b1;
         #1;
         if (in_ready) begin
            e.s = es; e.fl = efl; e.hit = ehit; e.lat = lat; e.due = cyc + ST0;
            q0.push_back(e);
            done = 1'b1;
         end
      end
      if (!done) begin
         n_total++;
         $display("FAIL issue_timeout: in_ready stayed 0, a=%h b=%h", ia, ib);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_valid = 1'b0; out_ready = 1'b1; sat_drv = 1'b0;
      end
   endtask

   task automatic issue1(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         input logic [31:0] es, input logic [5:0] efl);
      exp_t e;
      @(negedge clk);
      a1 = ia; b1 = ib; sub1 = isub; in_valid1 = 1'b1;
      #1;
      chk("in_ready1", 32'(in_ready1), 32'd1);
      e.s = es; e.fl = efl; e.hit = 1'b0; e.lat = 1'b1; e.due = cyc + 1;
      q1.push_back(e);
      @(negedge clk);
      in_valid1 = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          stalls;
      int          i;
      logic [31:0] v;
      exp_t        e;

      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0; sat_drv = 1'b0;
      in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s", s, 32'd0);
      chk("rst_flags", 32'(fl0), 32'd0);
      chk("rst_out_valid1", 32'(out_valid1), 32'd0);
      chk("rst_flags1", 32'(fl1), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(2);

      // Directed vectors, back-to-back, flags {cf,of,zf,pf,slt,sltu}
      issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 6'b101001, 1'b0, 1'b1);
      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 6'b100111, 1'b0, 1'b1);
      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 6'b010110, 1'b0, 1'b1);
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 6'b010100, 1'b0, 1'b1);
      issue(32'h0000_0007, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_0000, 6'b001000, 1'b0, 1'b1);
      issue(32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'h2143_6587, 6'b000100, 1'b0, 1'b1);
      issue(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 6'b000100, 1'b0, 1'b1);
      issue(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 6'b000100, 1'b0, 1'b1);
`ifdef ADDSUB_SAT_EN
      issue(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000, 6'b010110, 1'b1, 1'b1);
      issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 6'b010100, 1'b1, 1'b1);
      issue(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 6'b100111, 1'b0, 1'b1);
`endif
      idle(8);

      // Streaming with backpressure: out_ready low for stream cycles 3..6
      stalls = 0;
      i = 0;
      for (int t = 0; t < 100 && i < 8; t++) begin
         @(negedge clk);
         out_ready = !(t >= 3 && t <= 6);
         v = 32'h10 + 32'(i);
         a = 32'(i); b = 32'h10; sub = 1'b0; sat_drv = 1'b0; in_valid = 1'b1;
         #1;
         if (in_ready) begin
            e.s = v; e.fl = {3'b000, ^v, 2'b00}; e.hit = 1'b0; e.lat = 1'b0; e.due = 0;
            q0.push_back(e);
            i++;
         end else begin
            stalls++;
         end
      end
      chk("stream_accepted", 32'(i), 32'd8);
      chk("stall_cycles", 32'(stalls), 32'd3);
      idle(10);

      // Reset with three operations in flight
      issue(32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 6'b000100, 1'b0, 1'b0);
      issue(32'h2, 32'h1, 1'b0, 1'b0, 32'h3, 6'b000000, 1'b0, 1'b0);
      issue(32'h3, 32'h1, 1'b0, 1'b0, 32'h4, 6'b000100, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      q0.delete();
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #1;
         chk("post_rst_quiet", 32'(out_valid), 32'd0);
      end
      issue(32'h3, 32'h4, 1'b0, 1'b0, 32'h7, 6'b000100, 1'b0, 1'b1);
      idle(6);

      // Single-stage instance: latency 1
      issue1(16'h7FFF, 16'h0001, 1'b0, 32'h0000_8000, 6'b010100);
      issue1(16'h0000, 16'h0001, 1'b1, 32'h0000_FFFF, 6'b100011);
      issue1(16'hFFFF, 16'h0001, 1'b0, 32'h0000_0000, 6'b101001);
      idle(4);

      for (int k = 0; k < 40 && (q0.size() != 0 || q1.size() != 0); k++) begin
         @(negedge clk);
         #3;
      end
      if (q0.size() != 0 || q1.size() != 0) begin
         n_total++;
         $display("FAIL drain: %0d/%0d results never appeared", q0.size(), q1.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined integer adder/subtractor with full condition flags, for the multi-cycle and pipelined CPU datapaths.
- Splits the WIDTH-bit operation into CHUNK-bit carry-linked slices, one slice per pipeline stage.
- Registers the carry between stages.
- Carries a valid/ready handshake on input and output so the execute stage can stall.
- Produces the same flag set as the single-cycle ALU adder: CF, OF, ZF, PF, slt, sltu.

Parameters:
- WIDTH, 32: operand and result width; must be >= 2 and a multiple of CHUNK.
- CHUNK, 8: bits added per pipeline stage; must divide WIDTH.
- STAGES (localparam), WIDTH/CHUNK: pipeline depth, and therefore latency.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B (B inverted, carry-in 1)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- s  out  WIDTH  sum/difference
- cf  out  1  unsigned carry/borrow = sub ^ carry_out
- of  out  1  signed overflow = carry_out ^ carry_into_msb
- zf  out  1  s == 0
- pf  out  1  XOR-reduction of s (1 = odd number of ones)
- slt  out  1  of ^ s[WIDTH-1]
- sltu  out  1  equal to cf

Behaviour:
- Reset and clocking:
  - Single clock domain: clk. rst is asynchronous and active-high.
  - While rst is high: every stage valid bit = 0 and out_valid = 0; s, cf, of, zf, pf, slt, sltu = 0; in_ready = 1.
- Pipeline enable and handshake:
  - One global enable: adv = ~out_valid | out_ready. in_ready = adv (combinational).
  - A transfer occurs when in_valid & in_ready. Operands are captured on that edge; stage-0 valid = in_valid & adv.
  - While adv = 0, all stages hold: data, carries and valids are frozen.
  - out_valid and s/flags remain stable until out_ready is seen high.
  - Bubbles are permitted and propagate as valid = 0.
- Slice k (k = 0..STAGES-1):
  - Adds a[k*CHUNK +: CHUNK] and (b ^ {WIDTH{sub}})[k*CHUNK +: CHUNK] with the registered carry from slice k-1.
  - Slice 0 uses carry-in = sub.
  - Upper operand chunks are delayed alongside the carry; lower result chunks are delayed to align at the output.
- Latency: exactly STAGES cycles from accept to out_valid when there is no backpressure. Sustained throughput is 1 result per cycle.
- Flags are computed in the final stage from the full aligned result, carry_out and carry into bit WIDTH-1.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only through the flags, never by exception.
- Boundary conditions:
  - Simultaneous accept and output handshake in the same cycle is legal: pipeline full, out_ready = 1, in_valid = 1 gives no bubble.
  - out_ready = 0 with pipeline full: in_ready = 0; no loss and no duplication of results.
  - Reset mid-operation: all in-flight results are discarded; the first post-reset accept produces the next out_valid.
  - STAGES = 1 (CHUNK = WIDTH) degenerates to a single registered adder with latency 1.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- When defined:
  - Extra port sat (in, 1, travels down the pipeline with its operation).
  - Extra port sat_hit (out, 1, reset 0).
  - If sat = 1 and of = 1, s is clamped: 2^(WIDTH-1)-1 when A was non-negative, otherwise -2^(WIDTH-1). sat_hit = 1 in that case.
  - cf, of, slt and sltu reflect the raw result. zf and pf reflect the clamped s.
- When undefined: no sat or sat_hit ports; s is always the raw modulo result.

Decomposition:
- Package addsub_pkg:
  - Op encoding constants OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Flag bundle ordering {cf, of, zf, pf, slt, sltu} as a 6-bit constant-indexed vector.
  - Default WIDTH/CHUNK constants.
- Sub-module addsub_chunk: purely combinational CHUNK-bit slice. Inputs x, y, ci; outputs sum, co, c_msb (carry into the slice MSB). Instantiated STAGES times via generate.

Test Plan:
1. add 0xFFFFFFFF + 0x00000001 -> after 4 cycles s = 0x00000000, cf = 1, zf = 1, of = 0, pf = 0.
2. sub 5 - 7 -> s = 0xFFFFFFFE, cf = 1, sltu = 1, slt = 1, of = 0, pf = 1.
3. sub 0x80000000 - 1 -> s = 0x7FFFFFFF, of = 1, slt = 1, sltu = 0; with ADDSUB_SAT_EN and sat = 1 -> s = 0x80000000, sat_hit = 1.
4. Stream 8 back-to-back adds (i + 0x10) with out_ready low for cycles 3-6 -> in_ready drops while full; all 8 results delivered in order, none duplicated.
5. Accept 3 ops, assert rst for 1 cycle mid-flight -> out_valid stays 0 and no stale result appears; the next op after reset emerges 4 cycles after accept.
6. WIDTH = 16, CHUNK = 16, add 0x7FFF + 1 -> latency 1, s = 0x8000, of = 1, slt = 0, cf = 0.
